// File: rtl/cp0_regs_if.sv
// Pipeline-side bundle for cp0_regs: MTC0/MFC0 access, exception inputs and register taps.
interface cp0_regs_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] badvaddr_o;
  logic        timer_int_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, int_i,
           excepttype_i, current_inst_addr_i, is_in_delayslot_i, bad_addr_i,
    input  rdata_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o, timer_int_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, int_i,
           excepttype_i, current_inst_addr_i, is_in_delayslot_i, bad_addr_i,
    output rdata_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o, timer_int_o
  );
endinterface

// File: rtl/cp0_regs.sv
// CP0 register file: MTC0/MFC0 access, exception entry/ERET bookkeeping and timer interrupt.
// Register updates take effect at the next clock; MFC0 read is combinational; no backpressure.
module cp0_regs #(
  parameter logic [31:0] PRID            = 32'h0000_4220,
  parameter logic [31:0] CONFIG          = 32'h0000_8000,
  parameter bit          COUNT_HALF_RATE = 1'b1
) (
  input logic       clk,
  input logic       rst,
  cp0_regs_if.slave bus
);
  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [4:0] A_PRID     = 5'd15;
  localparam logic [4:0] A_CONFIG   = 5'd16;
  localparam logic [31:0] STATUS_RST = 32'h0040_0000;

  logic [31:0] count_q, compare_q, status_q, cause_q, epc_q, badvaddr_q;
  logic [31:0] count_d, compare_d, status_d, cause_d, epc_d, badvaddr_d;
  logic        timer_q, timer_d, phase_q, phase_d;
  logic        is_exc;

  always_comb begin
    is_exc = 1'b0;
    case (bus.excepttype_i)
      32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc: is_exc = 1'b1;
      default: is_exc = 1'b0;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    compare_d  = compare_q;
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    timer_d    = timer_q;
    phase_d    = ~phase_q;

    if (!COUNT_HALF_RATE || phase_q)
      count_d = count_q + 32'd1;
    if (compare_q != 32'd0 && count_q == compare_q)
      timer_d = 1'b1;
    cause_d[15:10] = {bus.int_i[5] | timer_q, bus.int_i[4:0]};

    // MTC0 first so that a same-cycle exception/ERET overrides only the fields it owns
    if (bus.we_i) begin
      case (bus.waddr_i)
        A_COUNT:   count_d = bus.wdata_i;
        A_COMPARE: begin
          compare_d = bus.wdata_i;
          timer_d   = 1'b0;
        end
        A_STATUS:  status_d = {9'd0, 1'b1, 6'd0, bus.wdata_i[15:8], 6'd0, bus.wdata_i[1:0]};
        A_CAUSE:   cause_d[9:8] = bus.wdata_i[9:8];
        A_EPC:     epc_d = bus.wdata_i;
        default: ;
      endcase
    end

    if (is_exc) begin
      // Nested exceptions keep the original return address
      if (!status_q[1]) begin
        epc_d      = bus.is_in_delayslot_i ? bus.current_inst_addr_i - 32'd4
                                           : bus.current_inst_addr_i;
        cause_d[31] = bus.is_in_delayslot_i;
      end
      status_d[1]  = 1'b1;
      cause_d[6:2] = (bus.excepttype_i == 32'h1) ? 5'd0 : bus.excepttype_i[4:0];
      if (bus.excepttype_i == 32'h4 || bus.excepttype_i == 32'h5)
        badvaddr_d = bus.bad_addr_i;
    end else if (bus.excepttype_i == 32'he) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      status_q   <= STATUS_RST;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      timer_q    <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      timer_q    <= timer_d;
      phase_q    <= phase_d;
    end
  end

  always_comb begin
    bus.rdata_o = 32'd0;
    case (bus.raddr_i)
      A_BADVADDR: bus.rdata_o = badvaddr_q;
      A_COUNT:    bus.rdata_o = count_q;
      A_COMPARE:  bus.rdata_o = compare_q;
      A_STATUS:   bus.rdata_o = status_q;
      A_CAUSE:    bus.rdata_o = cause_q;
      A_EPC:      bus.rdata_o = epc_q;
      A_PRID:     bus.rdata_o = PRID;
      A_CONFIG:   bus.rdata_o = CONFIG;
      default:    bus.rdata_o = 32'd0;
    endcase
  end

  assign bus.count_o     = count_q;
  assign bus.compare_o   = compare_q;
  assign bus.status_o    = status_q;
  assign bus.cause_o     = cause_q;
  assign bus.epc_o       = epc_q;
  assign bus.badvaddr_o  = badvaddr_q;
  assign bus.timer_int_o = timer_q;
endmodule
